// File: rtl/spi_master_if.sv
// Host-side request/reply bundle for spi_master.
// The SPI pins (MOSI, SS_n, MISO) stay plain ports on the master itself.
interface spi_master_if #(
    parameter int RD_W = 8
) ();
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_cmd;
    logic [7:0]      req_data;
    logic [RD_W-1:0] rd_data;
    logic            rd_valid;
    logic            busy;

    modport master (
        output req_valid, req_cmd, req_data,
        input  req_ready, rd_data, rd_valid, busy
    );

    modport slave (
        input  req_valid, req_cmd, req_data,
        output req_ready, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/spi_master.sv
// SPI initiator: shifts out 10-bit command frames MSB first and, for read-data
// commands, collects the RD_W-bit reply from MISO after RD_LAT idle cycles.
module spi_master #(
    parameter int FRAME_W = 10,
    parameter int RD_W    = 8,
    parameter int RD_LAT  = 2,
    parameter int GAP     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_master_if.slave host,
    output logic        MOSI,
    output logic        SS_n,
    input  logic        MISO
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [3:0] LAST_SHIFT = 4'(FRAME_W - 1);
    localparam logic [3:0] LAST_WAIT  = 4'(RD_LAT - 1);
    localparam logic [3:0] LAST_READ  = 4'(RD_W - 1);
    localparam logic [3:0] LAST_GAP   = 4'(GAP - 1);

    logic [2:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    // The final reply bit is taken straight from MISO, so only RD_W-1 bits are stored.
    logic [RD_W-2:0]    rx_q, rx_d;
    logic               is_read_q, is_read_d;
    logic [RD_W-1:0]    rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               ss_n_q, ss_n_d;
    logic               mosi_q, mosi_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q + 4'd1;
        tx_d       = tx_q;
        rx_d       = rx_q;
        is_read_d  = is_read_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (host.req_valid) begin
                    tx_d      = FRAME_W'({host.req_cmd, host.req_data});
                    is_read_d = (host.req_cmd == 2'b11);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                tx_d = tx_q << 1;
                if (cnt_q == LAST_SHIFT) begin
                    cnt_d = 4'd0;
                    if (!is_read_q)       state_d = S_GAP;
                    else if (RD_LAT == 0) state_d = S_READ;
                    else                  state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    cnt_d   = 4'd0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rx_d = {rx_q[RD_W-3:0], MISO};
                if (cnt_q == LAST_READ) begin
                    cnt_d      = 4'd0;
                    rd_data_d  = {rx_q, MISO};
                    rd_valid_d = 1'b1;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == LAST_GAP) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase

        // Pin values are derived from the next state so both pins come straight off flops.
        ss_n_d = (state_d == S_IDLE) || (state_d == S_GAP);
        mosi_d = (state_d == S_SHIFT) ? tx_d[FRAME_W-1] : 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            tx_q       <= '0;
            rx_q       <= '0;
            is_read_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            is_read_q  <= is_read_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign MOSI           = mosi_q;
    assign SS_n           = ss_n_q;
    assign host.req_ready = (state_q == S_IDLE);
    assign host.busy      = (state_q != S_IDLE);
    assign host.rd_data   = rd_data_q;
    assign host.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (RD_LAT=2 and RD_LAT=0)
// compared against a frame-level reference model and a behavioural SPI slave.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       miso;
    logic       sel;      // 0: observe/drive dut_a (RD_LAT=2), 1: dut_b (RD_LAT=0)

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_rd_a = 8'h00;

    always #5 clk = ~clk;

    spi_master_if #(.RD_W(8)) if_a ();
    spi_master_if #(.RD_W(8)) if_b ();
    logic mosi_a, ss_a, mosi_b, ss_b;

    assign if_a.req_valid = req_valid & ~sel;
    assign if_a.req_cmd   = req_cmd;
    assign if_a.req_data  = req_data;
    assign if_b.req_valid = req_valid & sel;
    assign if_b.req_cmd   = req_cmd;
    assign if_b.req_data  = req_data;

    spi_master #(.FRAME_W(10), .RD_W(8), .RD_LAT(2), .GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .host(if_a.slave),
        .MOSI(mosi_a), .SS_n(ss_a), .MISO(miso)
    );

    spi_master #(.FRAME_W(10), .RD_W(8), .RD_LAT(0), .GAP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .host(if_b.slave),
        .MOSI(mosi_b), .SS_n(ss_b), .MISO(miso)
    );

    logic       mosi_s, ss_s, rdy_s, busy_s, rdv_s;
    logic [7:0] rdd_s;
    assign mosi_s = sel ? mosi_b        : mosi_a;
    assign ss_s   = sel ? ss_b          : ss_a;
    assign rdy_s  = sel ? if_b.req_ready : if_a.req_ready;
    assign busy_s = sel ? if_b.busy     : if_a.busy;
    assign rdv_s  = sel ? if_b.rd_valid : if_a.rd_valid;
    assign rdd_s  = sel ? if_b.rd_data  : if_a.rd_data;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait for an IDLE cycle, present the request and let the next rising edge accept it.
    task automatic issue(input logic [1:0] c, input logic [7:0] d);
        int guard = 0;
        @(negedge clk);
        while (!rdy_s && guard < 60) begin
            guard++;
            @(negedge clk);
        end
        n_vec++;
        if (rdy_s !== 1'b1) begin
            n_err++;
            $display("FAIL issue_ready: req_ready=%b required 1", rdy_s);
        end
        req_cmd   = c;
        req_data  = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Observe one frame at negedges while acting as the SPI slave: the reply starts
    // lat cycles after the 10th MOSI bit. Returns after the first SS_n-high cycle.
    task automatic capture(input int lat, input logic [7:0] reply, input bit keep_valid,
                           output int high_before, output int low_cycles,
                           output logic [9:0] bits, output int extra_mosi,
                           output int rdv_cnt, output logic [7:0] rdd);
        int k;
        high_before = 0;
        low_cycles  = 0;
        bits        = '0;
        extra_mosi  = 0;
        rdv_cnt     = 0;
        rdd         = '0;
        @(negedge clk);
        while (ss_s && high_before < 60) begin
            high_before++;
            @(negedge clk);
        end
        if (!keep_valid) req_valid = 1'b0;
        while (!ss_s && low_cycles < 60) begin
            if (low_cycles < 10) bits = {bits[8:0], mosi_s};
            else if (mosi_s !== 1'b0) extra_mosi++;
            if (rdv_s !== 1'b0) rdv_cnt++;
            k = low_cycles - 10 - lat;
            miso = (k >= 0 && k < 8) ? reply[7-k] : 1'b0;
            low_cycles++;
            @(negedge clk);
        end
        miso = 1'b0;
        if (mosi_s !== 1'b0) extra_mosi++;
        if (rdv_s === 1'b1) begin
            rdv_cnt++;
            rdd = rdd_s;
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; req_valid = 1'b0; req_cmd = '0; req_data = '0; miso = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (ss_s !== 1'b1)  begin n_err++; $display("FAIL reset_ss_n: got %b want 1", ss_s); end
        n_vec++; if (mosi_s !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi_s); end
        n_vec++; if (rdy_s !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", rdy_s); end
        n_vec++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_s); end
        n_vec++; if (rdv_s !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rdv_s); end
        n_vec++; if (rdd_s !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", rdd_s); end
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        int hb, low, xm, rv; logic [9:0] b; logic [7:0] rd;
        issue(2'b00, 8'hA5);
        capture(2, 8'hFF, 1'b0, hb, low, b, xm, rv, rd);
        n_vec++; if (b !== 10'b00_1010_0101) begin n_err++; $display("FAIL write_mosi: got %b want 0010100101", b); end
        n_vec++; if (low !== 10) begin n_err++; $display("FAIL write_ss_low: got %0d want 10", low); end
        n_vec++; if (rv !== 0 || xm !== 0) begin n_err++; $display("FAIL write_extra: rd_valid=%0d stray_mosi=%0d want 0/0", rv, xm); end
        n_vec++; if (rdy_s !== 1'b0) begin n_err++; $display("FAIL write_ready_gap: got %b want 0", rdy_s); end
        @(negedge clk);
        n_vec++; if (rdy_s !== 1'b1) begin n_err++; $display("FAIL write_ready_back: got %b want 1", rdy_s); end
        n_vec++; if (rdd_s !== exp_rd_a) begin n_err++; $display("FAIL write_rd_hold: got %h want %h", rdd_s, exp_rd_a); end
    endtask

    task automatic test_read();
        int hb, low, xm, rv; logic [9:0] b; logic [7:0] rd;
        issue(2'b11, 8'h00);
        capture(2, 8'h3C, 1'b0, hb, low, b, xm, rv, rd);
        exp_rd_a = 8'h3C;
        n_vec++; if (b !== 10'b11_0000_0000) begin n_err++; $display("FAIL read_mosi: got %b want 1100000000", b); end
        n_vec++; if (low !== 20) begin n_err++; $display("FAIL read_ss_low: got %0d want 20", low); end
        n_vec++; if (rv !== 1) begin n_err++; $display("FAIL read_rd_valid_count: got %0d want 1", rv); end
        n_vec++; if (rd !== 8'h3C) begin n_err++; $display("FAIL read_rd_data: got %h want 3c", rd); end
        @(negedge clk);
        n_vec++; if (rdv_s !== 1'b0 || rdd_s !== 8'h3C) begin
            n_err++; $display("FAIL read_hold: rd_valid=%b rd_data=%h want 0/3c", rdv_s, rdd_s);
        end
    endtask

    task automatic test_back_to_back();
        int hb1, low1, xm1, rv1, hb2, low2, xm2, rv2;
        logic [9:0] b1, b2; logic [7:0] rd1, rd2;
        issue(2'b10, 8'h12);
        req_cmd  = 2'b01;
        req_data = 8'hFF;
        capture(2, 8'h00, 1'b1, hb1, low1, b1, xm1, rv1, rd1);
        capture(2, 8'h00, 1'b0, hb2, low2, b2, xm2, rv2, rd2);
        n_vec++; if (b1 !== 10'b10_0001_0010) begin n_err++; $display("FAIL b2b_mosi1: got %b want 1000010010", b1); end
        n_vec++; if (b2 !== 10'b01_1111_1111) begin n_err++; $display("FAIL b2b_mosi2: got %b want 0111111111", b2); end
        n_vec++; if (low1 !== 10 || low2 !== 10) begin n_err++; $display("FAIL b2b_ss_low: got %0d/%0d want 10/10", low1, low2); end
        // One high cycle is seen at the end of the first capture, the rest before the second.
        n_vec++; if (hb2 + 1 !== 2) begin n_err++; $display("FAIL b2b_gap: got %0d want 2", hb2 + 1); end
        n_vec++; if (rv1 + rv2 !== 0) begin n_err++; $display("FAIL b2b_rd_valid: got %0d want 0", rv1 + rv2); end
    endtask

    task automatic test_ignored();
        int hb, low, xm, rv, extra_low; logic [9:0] b; logic [7:0] rd, d;
        d = 8'($urandom);
        issue(2'b10, d);
        fork
            capture(2, 8'h00, 1'b0, hb, low, b, xm, rv, rd);
            begin
                repeat (3) @(negedge clk);
                n_vec++; if (rdy_s !== 1'b0) begin n_err++; $display("FAIL ign_ready: got %b want 0", rdy_s); end
                req_cmd   = 2'b01;
                req_data  = 8'($urandom);
                req_valid = 1'b1;
                @(negedge clk);
                req_valid = 1'b0;
            end
        join
        n_vec++; if (b !== {2'b10, d}) begin n_err++; $display("FAIL ign_mosi: got %b want %b", b, {2'b10, d}); end
        n_vec++; if (low !== 10) begin n_err++; $display("FAIL ign_ss_low: got %0d want 10", low); end
        extra_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (ss_s !== 1'b1) extra_low++;
        end
        n_vec++; if (extra_low !== 0) begin n_err++; $display("FAIL ign_no_frame: ss_n low %0d cycles want 0", extra_low); end
    endtask

    task automatic test_random();
        int hb, low, xm, rv;
        logic [9:0] b; logic [7:0] rd, d, reply; logic [1:0] c;
        repeat (24) begin
            c     = 2'($urandom_range(0, 3));
            d     = 8'($urandom);
            reply = 8'($urandom);
            issue(c, d);
            capture(2, reply, 1'b0, hb, low, b, xm, rv, rd);
            if (c == 2'b11) exp_rd_a = reply;
            n_vec++; if (b !== {c, d}) begin n_err++; $display("FAIL rand_mosi: got %b want %b", b, {c, d}); end
            n_vec++; if (low !== ((c == 2'b11) ? 20 : 10)) begin
                n_err++; $display("FAIL rand_ss_low: cmd=%b got %0d", c, low);
            end
            n_vec++; if (rv !== ((c == 2'b11) ? 1 : 0)) begin
                n_err++; $display("FAIL rand_rd_valid: cmd=%b got %0d pulses", c, rv);
            end
            n_vec++; if (rdd_s !== exp_rd_a || xm !== 0) begin
                n_err++; $display("FAIL rand_rd_data: got %h want %h stray_mosi=%0d", rdd_s, exp_rd_a, xm);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int hb, low, xm, rv; logic [9:0] b; logic [7:0] rd, d, reply;
        issue(2'b11, 8'($urandom));
        req_valid = 1'b0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_rd_a = 8'h00;
        n_vec++; if (ss_s !== 1'b1 || mosi_s !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_pins: ss_n=%b mosi=%b want 1/0", ss_s, mosi_s);
        end
        n_vec++; if (rdv_s !== 1'b0 || rdd_s !== 8'h00) begin
            n_err++; $display("FAIL rst_mid_rd: rd_valid=%b rd_data=%h want 0/00", rdv_s, rdd_s);
        end
        n_vec++; if (busy_s !== 1'b0 || rdy_s !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_state: busy=%b ready=%b want 0/1", busy_s, rdy_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        d     = 8'($urandom);
        reply = 8'($urandom);
        issue(2'b11, d);
        capture(2, reply, 1'b0, hb, low, b, xm, rv, rd);
        exp_rd_a = reply;
        n_vec++; if (b !== {2'b11, d} || low !== 20) begin
            n_err++; $display("FAIL rst_clean_frame: mosi=%b low=%0d want %b/20", b, low, {2'b11, d});
        end
        n_vec++; if (rv !== 1 || rd !== reply) begin
            n_err++; $display("FAIL rst_clean_read: pulses=%0d data=%h want 1/%h", rv, rd, reply);
        end
    endtask

    task automatic test_rdlat0();
        int hb, low, xm, rv; logic [9:0] b; logic [7:0] rd, d;
        sel = 1'b1;
        d   = 8'($urandom);
        issue(2'b11, d);
        capture(0, 8'h81, 1'b0, hb, low, b, xm, rv, rd);
        n_vec++; if (b !== {2'b11, d}) begin n_err++; $display("FAIL lat0_mosi: got %b want %b", b, {2'b11, d}); end
        n_vec++; if (low !== 18) begin n_err++; $display("FAIL lat0_ss_low: got %0d want 18", low); end
        n_vec++; if (rv !== 1 || rd !== 8'h81) begin
            n_err++; $display("FAIL lat0_rd: pulses=%0d data=%h want 1/81", rv, rd);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_ignored();
        test_random();
        test_reset_mid_frame();
        test_rdlat0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Initiator end of the SPI link, on the same clk as the slave: it drives SS_n and MOSI and samples MISO.
- A host issues 10-bit command frames: req_cmd[1:0] followed by req_data[7:0].
- For read-data commands (cmd 2'b11) the block also collects the 8-bit RAM reply from MISO.
- Sits between test/host logic and the SPI slave + single-port RAM subsystem; one SPI bit per clk cycle.

Parameters:
- FRAME_W, 10: bits shifted out per frame (2 cmd + 8 data).
- RD_W, 8: reply bits captured on MISO for cmd 2'b11.
- RD_LAT, 2: cycles between the last MOSI bit and the first valid MISO bit (legal range 0..15).
- GAP, 1: minimum cycles SS_n held high between frames (legal range 1..15).

Ports:
- clk, input, 1: system/SPI clock; all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: host request valid.
- req_ready, output, 1: block can accept a request.
- req_cmd, input, 2: command (00 wr addr, 01 wr data, 10 rd addr, 11 rd data).
- req_data, input, 8: address/data byte.
- MOSI, output, 1: serial data to slave, MSB first.
- SS_n, output, 1: active-low slave select.
- MISO, input, 1: serial reply from slave.
- rd_data, output, RD_W: last captured reply.
- rd_valid, output, 1: one-cycle pulse, rd_data updated.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-frame): state IDLE, SS_n=1, MOSI=0, req_ready=1, busy=0, rd_valid=0, rd_data=0, all counters and shift registers 0.
- States: IDLE, SHIFT, WAIT, READ, GAP.
- IDLE:
  - req_ready=1, SS_n=1, MOSI=0.
  - Accept on a rising edge with req_valid=1: latch {req_cmd, req_data} into a 10-bit shift register, latch is_read=(req_cmd==2'b11), go to SHIFT.
- SHIFT:
  - SS_n=0; MOSI = shift register bit 9 (req_cmd[1] first, req_data[0] last).
  - Shift left each cycle; lasts exactly FRAME_W cycles.
  - After the 10th bit: go to WAIT if is_read, else GAP.
- WAIT: SS_n=0, MOSI=0, for RD_LAT cycles; if RD_LAT=0 go straight to READ.
- READ:
  - SS_n=0, MOSI=0; sample MISO at each rising edge into the rx shift register, MSB first, for exactly RD_W cycles.
  - On the last sample go to GAP: load rd_data with the assembled byte and assert rd_valid for exactly one cycle, coincident with the first GAP cycle.
- GAP: SS_n=1, MOSI=0, for GAP cycles, then IDLE.
- req_ready is high only in IDLE.
  - req_valid while not in IDLE is ignored; the request is neither queued nor partially latched.
  - A request held valid is accepted on the first IDLE cycle.
- SS_n low duration:
  - Exactly FRAME_W cycles for non-read commands.
  - Exactly FRAME_W+RD_LAT+RD_W cycles for cmd 11.
  - No glitches; SS_n and MOSI are registered outputs.
- Back-to-back requests: SS_n high for exactly GAP cycles plus 1 IDLE cycle between frames.
- rd_data holds its value until the next completed read; it never changes for non-read commands.
- Frame-position counter: 4-bit, wraps to 0 at each state change.

Test Plan:
- cmd=00, data=0xA5, RD_LAT=2 -> MOSI per cycle 0,0,1,0,1,0,0,1,0,1; SS_n low exactly 10 cycles; rd_valid never asserted; req_ready returns high 1 cycle after SS_n rises.
- cmd=11, data=0x00, slave model drives 0x3C on MISO starting 2 cycles after the last MOSI bit -> rd_data=0x3C; rd_valid high exactly one cycle; SS_n low exactly 20 cycles.
- req_valid held high across two requests (cmd=10 data=0x12, then cmd=01 data=0xFF) -> second frame starts with SS_n high for exactly 2 cycles between frames; both MOSI sequences correct.
- req_valid pulsed with cmd=01 during SHIFT of a prior frame -> ignored; req_ready=0; no extra frame; MOSI of the current frame unaffected.
- rst_n asserted at bit 5 of a cmd=11 frame -> SS_n=1, MOSI=0 immediately (before the next edge); rd_valid stays 0; rd_data=0; next request after reset runs a clean full frame.
- RD_LAT=0, cmd=11, MISO returns 0x81 -> first MISO sample on the cycle after the 10th MOSI bit; rd_data=0x81; SS_n low exactly 18 cycles.
